// File: rtl/smc_stream.sv
// Streaming MOSFET calculator: ranks per-device Id/gm values and returns a weighted top/bottom-K sum.
// Optional SMC_ARGMAX_EN adds out_idx, the arrival index of the largest value.
module smc_stream #(
  parameter int N_DEV  = 6,
  parameter int K_SEL  = 3,
  parameter int W_BITS = 3,
  parameter int OUT_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               mode,
  input  logic [W_BITS-1:0]        W,
  input  logic [W_BITS-1:0]        V_GS,
  input  logic [W_BITS-1:0]        V_DS,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_n
`ifdef SMC_ARGMAX_EN
  ,
  output logic [$clog2(N_DEV)-1:0] out_idx
`endif
);

  localparam int VAL_W  = 3*W_BITS+2;
  localparam int IDX_W  = $clog2(N_DEV);
  localparam int STEP_W = $clog2(K_SEL+1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]        state;
  logic [IDX_W-1:0]  cnt;
  logic [STEP_W-1:0] step;
  logic [1:0]        mode_q;
  logic [OUT_W-1:0]  acc;
  logic [VAL_W-1:0]  rank_val [N_DEV];
`ifdef SMC_ARGMAX_EN
  logic [IDX_W-1:0]  rank_idx [N_DEV];
`endif

  logic [VAL_W-1:0]  w_e, vgs_e, vds_e, v_e, id_val, gm_val, dev_val, sel_val;
  logic              dev_is_id, beat;
  logic [IDX_W:0]    ins_pos, sel_pos;
  logic [OUT_W-1:0]  wt, term;

  assign in_ready  = (state == S_IDLE) || (state == S_LOAD);
  assign out_valid = (state == S_OUT);
  assign beat      = in_valid && in_ready;

  // Device value; on beat 0 the incoming mode applies because mode_q is not yet loaded
  always_comb begin
    w_e    = VAL_W'(W);
    vgs_e  = VAL_W'(V_GS);
    vds_e  = VAL_W'(V_DS);
    v_e    = vgs_e - VAL_W'(1);
    id_val = '0;
    gm_val = '0;
    if (V_GS > W_BITS'(1)) begin
      if (v_e > vds_e) begin
        id_val = (w_e * vds_e * ((v_e << 1) - vds_e)) / VAL_W'(3);
        gm_val = ((w_e * vds_e) << 1) / VAL_W'(3);
      end else begin
        id_val = (w_e * v_e * v_e) / VAL_W'(3);
        gm_val = ((w_e * v_e) << 1) / VAL_W'(3);
      end
    end
    dev_is_id = (state == S_IDLE) ? mode[0] : mode_q[0];
    dev_val   = dev_is_id ? id_val : gm_val;
  end

  // New entry goes after every stored value >= it, so equal values keep arrival order
  always_comb begin
    ins_pos = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if ((IDX_W'(i) < cnt) && (rank_val[i] >= dev_val))
        ins_pos = (IDX_W+1)'(i+1);
    end
  end

  always_comb begin
    sel_pos = mode_q[1] ? (IDX_W+1)'(step)
                        : (IDX_W+1)'(N_DEV-K_SEL) + (IDX_W+1)'(step);
    sel_val = '0;
    if (sel_pos < (IDX_W+1)'(N_DEV))
      sel_val = rank_val[sel_pos[IDX_W-1:0]];
    wt   = mode_q[0] ? (OUT_W'(3) + OUT_W'(step)) : OUT_W'(1);
    term = wt * OUT_W'(sel_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_DEV; i++) begin
        rank_val[i] <= '0;
`ifdef SMC_ARGMAX_EN
        rank_idx[i] <= '0;
`endif
      end
    end else if (beat) begin
      if (ins_pos == '0) begin
        rank_val[0] <= dev_val;
`ifdef SMC_ARGMAX_EN
        rank_idx[0] <= cnt;
`endif
      end
      for (int i = 1; i < N_DEV; i++) begin
        if ((IDX_W+1)'(i) == ins_pos) begin
          rank_val[i] <= dev_val;
`ifdef SMC_ARGMAX_EN
          rank_idx[i] <= cnt;
`endif
        end else if ((IDX_W+1)'(i) > ins_pos) begin
          rank_val[i] <= rank_val[i-1];
`ifdef SMC_ARGMAX_EN
          rank_idx[i] <= rank_idx[i-1];
`endif
        end
      end
    end
  end

  // CALC spends one extra cycle after the last step to register the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      step   <= '0;
      mode_q <= '0;
      acc    <= '0;
      out_n  <= '0;
`ifdef SMC_ARGMAX_EN
      out_idx <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (beat) begin
          mode_q <= mode;
          cnt    <= IDX_W'(1);
          state  <= S_LOAD;
        end
        S_LOAD: if (beat) begin
          if (cnt == IDX_W'(N_DEV-1)) begin
            cnt   <= '0;
            step  <= '0;
            acc   <= '0;
            state <= S_CALC;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        S_CALC: begin
          if (step == STEP_W'(K_SEL)) begin
            out_n <= acc;
`ifdef SMC_ARGMAX_EN
            out_idx <= rank_idx[0];
`endif
            state <= S_OUT;
          end else begin
            acc  <= acc + term;
            step <= step + STEP_W'(1);
          end
        end
        default: if (out_ready) begin
          acc   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smc_stream.sv
// Randomized self-checking bench for smc_stream against a sort-and-sum reference model.
// Checks out_idx too when SMC_ARGMAX_EN is defined.
module tb_smc_stream;

  localparam int N_DEV  = 6;
  localparam int K_SEL  = 3;
  localparam int W_BITS = 3;
  localparam int OUT_W  = 10;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [1:0] mode;
  logic [W_BITS-1:0] W, V_GS, V_DS;
  logic [OUT_W-1:0] out_n;
`ifdef SMC_ARGMAX_EN
  logic [$clog2(N_DEV)-1:0] out_idx;
`endif

  int total = 0;
  int bad   = 0;
  int fw [N_DEV];
  int fg [N_DEV];
  int fd [N_DEV];

  always #5 clk = ~clk;

  smc_stream #(.N_DEV(N_DEV), .K_SEL(K_SEL), .W_BITS(W_BITS), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .W(W), .V_GS(V_GS), .V_DS(V_DS), .out_valid(out_valid), .out_ready(out_ready),
    .out_n(out_n)
`ifdef SMC_ARGMAX_EN
    , .out_idx(out_idx)
`endif
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Square-law model with Kn=1/3, Vth=1, floored division
  function automatic int dev_value(input bit is_id, input int w, input int vgs, input int vds);
    int v;
    if (vgs <= 1) return 0;
    v = vgs - 1;
    if (v > vds) return is_id ? (w*vds*(2*v - vds))/3 : (2*w*vds)/3;
    return is_id ? (w*v*v)/3 : (2*w*v)/3;
  endfunction

  function automatic void model(input logic [1:0] m, output int sum, output int amax);
    int  vals  [N_DEV];
    int  order [N_DEV];
    bit  used  [N_DEV];
    int  best, r;
    for (int i = 0; i < N_DEV; i++) begin
      vals[i] = dev_value(m[0], fw[i], fg[i], fd[i]);
      used[i] = 1'b0;
    end
    for (int k = 0; k < N_DEV; k++) begin
      best = -1;
      for (int i = 0; i < N_DEV; i++)
        if (!used[i] && (best < 0 || vals[i] > vals[best])) best = i;
      order[k] = best;
      used[best] = 1'b1;
    end
    sum = 0;
    for (int j = 0; j < K_SEL; j++) begin
      r = m[1] ? j : N_DEV - K_SEL + j;
      sum += (m[0] ? 3 + j : 1) * vals[order[r]];
    end
    sum  = sum % (1 << OUT_W);
    amax = order[0];
  endfunction

  task automatic applyStimulus(input int k, input logic [1:0] m, input int gap);
    in_valid = 1'b1;
    mode = (k == 0) ? m : 2'($urandom);
    W    = W_BITS'(fw[k]);
    V_GS = W_BITS'(fg[k]);
    V_DS = W_BITS'(fd[k]);
    checkOutput("in_ready_beat", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode = 2'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic set_all(input int w, input int g, input int d);
    for (int i = 0; i < N_DEV; i++) begin fw[i] = w; fg[i] = g; fd[i] = d; end
  endtask

  task automatic set_random();
    for (int i = 0; i < N_DEV; i++) begin
      fw[i] = int'($urandom_range(0, 7));
      fg[i] = int'($urandom_range(0, 7));
      fd[i] = int'($urandom_range(0, 7));
    end
  endtask

  task automatic run_frame(input logic [1:0] m, input int hold, input bit early, input bit gaps);
    int exp_sum, exp_idx, cyc;
    logic [OUT_W-1:0] held;
    model(m, exp_sum, exp_idx);
    for (int k = 0; k < N_DEV; k++)
      applyStimulus(k, m, (gaps && k < N_DEV-1) ? int'($urandom_range(0, 2)) : 0);
    checkOutput("in_ready_calc", int'(in_ready), 0);
    checkOutput("valid_early", int'(out_valid), 0);
    out_ready = early;
    cyc = 0;
    // Random beats here must be ignored while the block is busy
    while (!out_valid && cyc < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      W = W_BITS'($urandom); V_GS = W_BITS'($urandom); V_DS = W_BITS'($urandom);
      mode = 2'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("latency", cyc, K_SEL + 1);
    checkOutput("out_n", int'(out_n), exp_sum);
`ifdef SMC_ARGMAX_EN
    checkOutput("out_idx", int'(out_idx), exp_idx);
`endif
    held = out_n;
    if (!early) begin
      repeat (hold) begin
        in_valid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checkOutput("hold_out_n", int'(out_n), int'(held));
      checkOutput("hold_valid", int'(out_valid), 1);
      checkOutput("hold_in_ready", int'(in_ready), 0);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("release_valid", int'(out_valid), 0);
    checkOutput("release_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 2'b00;
    W = '0; V_GS = '0; V_DS = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_n", int'(out_n), 0);
`ifdef SMC_ARGMAX_EN
    checkOutput("reset_out_idx", int'(out_idx), 0);
`endif
    rst = 1'b0;

    set_all(1, 3, 3); run_frame(2'b01, 0, 1'b0, 1'b0);
    set_all(1, 3, 3); run_frame(2'b00, 2, 1'b0, 1'b0);
    set_all(7, 7, 7); run_frame(2'b11, 5, 1'b0, 1'b0);
    set_all(7, 0, 7); fg[0] = 7; run_frame(2'b11, 0, 1'b1, 1'b0);
    set_all(7, 0, 7); fg[0] = 7; run_frame(2'b01, 1, 1'b0, 1'b0);
    set_all(3, 4, 1); run_frame(2'b11, 3, 1'b0, 1'b1);
    set_all(3, 4, 1); run_frame(2'b10, 0, 1'b1, 1'b1);

    // Abort a frame after beat 3, then a clean frame must still be correct
    set_random();
    for (int k = 0; k < 4; k++) applyStimulus(k, 2'b11, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midreset_out_valid", int'(out_valid), 0);
    checkOutput("midreset_in_ready", int'(in_ready), 1);
    checkOutput("midreset_out_n", int'(out_n), 0);
    set_random(); run_frame(2'b11, 1, 1'b0, 1'b0);

    for (int f = 0; f < 30; f++) begin
      set_random();
      run_frame(2'($urandom), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
